// File: rtl/branch_pkg.sv
// Shared branch-type encodings, FSM state type and small decode helpers
// for the sequential branch comparator.
package branch_pkg;

    localparam logic [2:0] BT_EQ  = 3'b000;
    localparam logic [2:0] BT_NE  = 3'b001;
    localparam logic [2:0] BT_LT  = 3'b100;
    localparam logic [2:0] BT_GE  = 3'b101;
    localparam logic [2:0] BT_LTU = 3'b110;
    localparam logic [2:0] BT_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // funct3 010 and 011 are not conditional branches
    function automatic logic is_legal_btype(input logic [2:0] bt);
        return bt[2:1] != 2'b01;
    endfunction

    function automatic logic is_signed_btype(input logic [2:0] bt);
        return bt[2:1] == 2'b10;
    endfunction

    // lt is 0 whenever eq is 1, so one mapping covers both the early-exit
    // and the all-chunks-equal outcomes.
    function automatic logic resolve_taken(input logic [2:0] bt,
                                           input logic eq,
                                           input logic lt);
        logic res;
        res = 1'b0;
        case (bt)
            BT_EQ:          res = eq;
            BT_NE:          res = !eq;
            BT_LT, BT_LTU:  res = lt;
            BT_GE, BT_GEU:  res = !lt;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Unsigned equality / less-than compare of one operand chunk.
module branch_chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch resolver: compares operands CHUNK_W bits per cycle,
// MSB-first, exiting on the first differing chunk; reports mispredict.
module branch_compare_seq
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CHUNK_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      btype,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict,
    output logic            illegal_type
);

    // state | meaning
    // IDLE  | waiting for a request; only state with in_ready=1
    // CMP   | comparing chunk r_idx, walking from MSB chunk down to chunk 0
    // DONE  | result presented on out_valid until the consumer takes it

    localparam int NUM_CHUNKS = XLEN / CHUNK_W;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [XLEN-1:0]   SIGN_MASK = {1'b1, {(XLEN-1){1'b0}}};

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [2:0]       r_btype;
    logic             r_pred;
    logic             r_valid;
    logic             r_taken;
    logic             r_misp;
    logic             r_illegal;

    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] w_a_chunks;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] w_b_chunks;
    logic [CHUNK_W-1:0] w_a_sel;
    logic [CHUNK_W-1:0] w_b_sel;
    logic               w_eq;
    logic               w_lt;
    logic               w_res;
    logic [XLEN-1:0]    w_flip;

    assign in_ready     = (r_state == IDLE) && !flush;
    assign out_valid    = r_valid;
    assign taken        = r_taken;
    assign mispredict   = r_misp;
    assign illegal_type = r_illegal;

    // Flipping the sign bit maps signed order onto unsigned order.
    assign w_flip = is_signed_btype(btype) ? SIGN_MASK : '0;

    assign w_a_chunks = r_a;
    assign w_b_chunks = r_b;
    assign w_a_sel    = w_a_chunks[r_idx];
    assign w_b_sel    = w_b_chunks[r_idx];

    branch_chunk_cmp #(.W(CHUNK_W)) u_chunk_cmp (
        .a  (w_a_sel),
        .b  (w_b_sel),
        .eq (w_eq),
        .lt (w_lt)
    );

    assign w_res = resolve_taken(r_btype, w_eq, w_lt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_btype   <= '0;
            r_pred    <= 1'b0;
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_misp    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_misp    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a     <= rs1_data ^ w_flip;
                        r_b     <= rs2_data ^ w_flip;
                        r_btype <= btype;
                        r_pred  <= pred_taken;
                        r_idx   <= IDX_TOP;
                        if (is_legal_btype(btype)) begin
                            r_state <= CMP;
                        end else begin
                            r_state   <= DONE;
                            r_valid   <= 1'b1;
                            r_taken   <= 1'b0;
                            r_misp    <= pred_taken;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    if (!w_eq || (r_idx == '0)) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_taken <= w_res;
                        r_misp  <= w_res ^ r_pred;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        r_valid   <= 1'b0;
                        r_taken   <= 1'b0;
                        r_misp    <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Scoreboard bench for branch_compare_seq: directed requests push expected
// results; a monitor pops and compares on each output handshake.
module tb_branch_compare_seq;

    typedef struct {
        logic taken;
        logic misp;
        logic ill;
        int   lat;
        int   acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  btype = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken;
    logic        mispredict;
    logic        illegal_type;

    logic        alt_valid = 1'b0;
    logic [2:0]  alt_bt = 3'b000;
    logic [31:0] alt_a = '0;
    logic [31:0] alt_b = '0;
    logic        a32_rdy, a32_ov, a32_t, a32_m, a32_i;
    logic        a1_rdy, a1_ov, a1_t, a1_m, a1_i;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    bit   mon_seen = 0;
    int   mon_first = 0;
    logic h_t, h_m, h_i;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    branch_compare_seq #(.XLEN(32), .CHUNK_W(8)) u_dut (
        .clk(clk), .rst(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .btype(btype), .rs1_data(rs1), .rs2_data(rs2), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
        .mispredict(mispredict), .illegal_type(illegal_type)
    );

    branch_compare_seq #(.XLEN(32), .CHUNK_W(32)) u_dut32 (
        .clk(clk), .rst(rst_n), .flush(1'b0), .in_valid(alt_valid), .in_ready(a32_rdy),
        .btype(alt_bt), .rs1_data(alt_a), .rs2_data(alt_b), .pred_taken(1'b0),
        .out_valid(a32_ov), .out_ready(1'b1), .taken(a32_t),
        .mispredict(a32_m), .illegal_type(a32_i)
    );

    branch_compare_seq #(.XLEN(32), .CHUNK_W(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .flush(1'b0), .in_valid(alt_valid), .in_ready(a1_rdy),
        .btype(alt_bt), .rs1_data(alt_a), .rs2_data(alt_b), .pred_taken(1'b0),
        .out_valid(a1_ov), .out_ready(1'b1), .taken(a1_t),
        .mispredict(a1_m), .illegal_type(a1_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge so driver updates have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mon_seen = 0;
                continue;
            end
            if (!out_valid) begin
                chk("idle_outputs_zero", {taken, mispredict, illegal_type}, 3'b000);
            end else begin
                if (!mon_seen) begin
                    mon_seen  = 1;
                    mon_first = cyc;
                    h_t = taken; h_m = mispredict; h_i = illegal_type;
                end else begin
                    chk("hold_stable", {taken, mispredict, illegal_type}, {h_t, h_m, h_i});
                end
                if (!out_ready) chk("in_ready_busy", in_ready, 1'b0);
                if (out_ready) begin
                    mon_seen = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=valid expected=none");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("taken", taken, e.taken);
                        chk("mispredict", mispredict, e.misp);
                        chk("illegal_type", illegal_type, e.ill);
                        chk("latency", mon_first - e.acc, e.lat);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("done_timeout", exp_q.size(), 0);
    endtask

    task automatic send(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b,
                        input logic pred, input logic et, input logic em, input logic ei,
                        input int elat, input bit push, input bit wait_done);
        int n = 0;
        @(negedge clk);
        btype = bt; rs1 = a; rs2 = b; pred_taken = pred; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
        if (push) exp_q.push_back('{et, em, ei, elat, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(nm, out_valid, 1'b1);
    endtask

    task automatic run_alt(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b,
                           input logic et, input int l32_exp, input int l1_exp);
        int l32 = -1;
        int l1 = -1;
        logic t32 = 1'b0;
        logic t1 = 1'b0;
        @(negedge clk);
        alt_bt = bt; alt_a = a; alt_b = b; alt_valid = 1'b1;
        #1;
        chk("alt_ready", {a32_rdy, a1_rdy}, 2'b11);
        @(posedge clk);
        @(negedge clk);
        alt_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (a32_ov && l32 < 0) begin l32 = c; t32 = a32_t; end
            if (a1_ov && l1 < 0) begin l1 = c; t1 = a1_t; end
            if (l32 >= 0 && l1 >= 0) break;
            @(negedge clk);
        end
        chk("alt32_latency", l32, l32_exp);
        chk("alt1_latency", l1, l1_exp);
        chk("alt_taken", {t32, t1}, {et, et});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_outputs", {taken, mispredict, illegal_type}, 3'b000);
        chk("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        //    btype   rs1           rs2           pred  t  m  i  lat
        send(3'b000, 32'h12345678, 32'h12345678, 1'b0, 1, 1, 0, 4, 1, 1);
        send(3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 0, 0, 1, 1, 1);
        send(3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1, 0, 1, 1, 1);

        out_ready = 1'b0;
        send(3'b111, 32'h00000100, 32'h000000FF, 1'b0, 1, 1, 0, 3, 1, 0);
        wait_valid("hold_valid_seen");
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        send(3'b010, 32'h00000005, 32'h00000005, 1'b1, 0, 1, 1, 0, 1, 1);
        send(3'b011, 32'h00000000, 32'h00000001, 1'b0, 0, 0, 1, 0, 1, 1);
        send(3'b101, 32'hFFFFFFFB, 32'h00000003, 1'b0, 0, 0, 0, 1, 1, 1);
        send(3'b101, 32'h80000000, 32'h80000000, 1'b1, 1, 0, 0, 4, 1, 1);
        send(3'b100, 32'h00000010, 32'h00000020, 1'b1, 1, 0, 0, 4, 1, 1);
        send(3'b001, 32'hAB000000, 32'hAC000000, 1'b1, 1, 0, 0, 1, 1, 1);

        // Flush during the second compare cycle of an all-equal BNE.
        send(3'b001, 32'h55555555, 32'h55555555, 1'b0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_in_ready", in_ready, 1'b1);
        repeat (6) @(negedge clk);
        chk("flush_no_valid", out_valid, 1'b0);
        send(3'b001, 32'h00000001, 32'h00000002, 1'b0, 1, 1, 0, 4, 1, 1);

        // Reset in the middle of a compare.
        send(3'b000, 32'h12345678, 32'h12345678, 1'b0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcmp_rst_in_ready", in_ready, 1'b1);
        chk("midcmp_rst_outputs", {out_valid, taken, mispredict, illegal_type}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midcmp_rst_no_valid", out_valid, 1'b0);

        // Reset while a result is being held.
        out_ready = 1'b0;
        send(3'b001, 32'h00000001, 32'h00000002, 1'b0, 0, 0, 0, 0, 0, 0);
        wait_valid("held_valid_before_rst");
        chk("held_result", {taken, mispredict}, 2'b11);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mon_seen = 0;
        #1;
        chk("done_rst_outputs", {out_valid, taken, mispredict, illegal_type}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        send(3'b110, 32'h00000000, 32'h00000001, 1'b1, 1, 0, 0, 4, 1, 1);

        //       btype   rs1           rs2           t  l32 l1
        run_alt(3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 32);
        run_alt(3'b110, 32'h80000000, 32'h00000000, 0, 1, 1);
        run_alt(3'b100, 32'h80000000, 32'h00000000, 1, 1, 1);
        run_alt(3'b110, 32'h00000000, 32'h00000001, 1, 1, 32);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_compare_seq.md
Name: branch_compare_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle branch comparator in the EX stage.
- Resolves RV32/RV64 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) by comparing operands CHUNK_W bits per cycle, MSB-first, with early exit on the first differing chunk.
- Uses a valid/ready handshake on both sides.
- Also reports mispredict against the front-end's predicted direction.
- Sits between the operand-forwarding mux and the branch-redirect logic; flush comes from the hazard unit.

Parameters:
XLEN, 32, operand width; must be a multiple of CHUNK_W.
CHUNK_W, 8, bits compared per cycle; power of two, 1..XLEN; CHUNK_W==XLEN gives a one-compare-cycle unit.
NUM_CHUNKS, XLEN/CHUNK_W, derived localparam, not overridable.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of any in-flight compare
in_valid  in  1  request valid
in_ready  out  1  unit can accept; combinational = (state==IDLE) && !flush
btype  in  3  funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
rs1_data  in  XLEN  operand 1
rs2_data  in  XLEN  operand 2
pred_taken  in  1  predicted direction from front-end
out_valid  out  1  result valid (registered)
out_ready  in  1  consumer accepts result
taken  out  1  resolved branch direction
mispredict  out  1  taken XOR captured pred_taken
illegal_type  out  1  btype was 010 or 011

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid, taken, mispredict, illegal_type, chunk index and operand/btype/pred registers all 0.
- FSM states IDLE, CMP, DONE. Only one operation is in flight at a time; in_ready=0 outside IDLE.
- IDLE, on accept (in_valid && in_ready):
  - Capture operands, btype and pred_taken; set idx=NUM_CHUNKS-1.
  - Legal btype → CMP.
  - Illegal btype → DONE directly with taken=0, illegal_type=1, mispredict=pred_taken.
- Signed types: invert bit XLEN-1 of both captured operands, then treat all compares as unsigned.
- CMP, each cycle:
  - Compare chunk idx of both operands and produce eq_c and lt_c.
  - If !eq_c: decide now. EQ→0, NE→1, LT/LTU→lt_c, GE/GEU→!lt_c. Go to DONE.
  - Else if idx==0: operands are equal. EQ→1, NE→0, LT/LTU→0, GE/GEU→1. Go to DONE.
  - Else: idx−1 and stay in CMP.
- Latency: out_valid rises k cycles after the accept edge, where k is the number of chunks examined (1..NUM_CHUNKS). Equal operands give k=NUM_CHUNKS. Illegal btype gives out_valid in the cycle after accept.
- DONE: out_valid=1. taken, mispredict and illegal_type are held stable while out_ready=0. On out_valid && out_ready, go to IDLE; out_valid=0 next cycle. There is no same-cycle re-accept; the next accept is possible the cycle after returning to IDLE.
- flush=1, synchronous, highest priority in any state:
  - Next state is IDLE; out_valid=0 next cycle; result outputs cleared to 0.
  - in_ready is forced 0, so no accept occurs in a flush cycle.
  - A simultaneous out_ready handshake in DONE completes (consumer sampled it), and the state still goes to IDLE.
- Outputs taken, mispredict and illegal_type are 0 whenever out_valid=0.
- Asserting rst mid-CMP aborts the compare immediately with no partial result.

Decomposition:
- Shared package branch_pkg:
  - BT_EQ/BT_NE/BT_LT/BT_GE/BT_LTU/BT_GEU 3-bit constants.
  - State enum {IDLE, CMP, DONE}.
  - Function is_legal_btype.
  - Helper is_signed_btype.
- One combinational sub-module, branch_chunk_cmp:
  - Parameter W=CHUNK_W.
  - Inputs a, b; outputs eq and lt (unsigned).
  - Instantiated once, fed by the idx-selected slice.

Test Plan:
- XLEN=32, CHUNK_W=8, BEQ, rs1=rs2=0x1234_5678, pred_taken=0, out_ready=1 → out_valid 4 cycles after accept, taken=1, mispredict=1.
- BLT, rs1=0xFFFF_FFFF (−1), rs2=0x0000_0001 → top chunk differs, out_valid 1 cycle after accept, taken=1. Same operands with BLTU → taken=0.
- BGEU, rs1=0x0000_0100, rs2=0x0000_00FF → decided at chunk 1, out_valid 3 cycles after accept, taken=1. Hold out_ready=0 for 5 cycles → out_valid and taken stable; in_ready=0 throughout.
- btype=010, pred_taken=1 → out_valid next cycle, illegal_type=1, taken=0, mispredict=1.
- BNE with equal operands, flush asserted in 2nd CMP cycle → out_valid never rises. in_ready=1 the cycle after flush; a fresh request (BNE, 1 vs 2) then completes normally with taken=1.
- rst pulsed low mid-CMP → all outputs 0 asynchronously, state IDLE. Regression rerun with CHUNK_W=32 and CHUNK_W=1 → BEQ equal latency 1 and 32 respectively.
